// File: rtl/microcode_sequencer.sv
// Microcode sequencer: latches the ROM word addressed by {cond_var, opcode, upc},
// steps the micro-op counter, tracks interrupt enable and flags counter overflow.
// The word held in CTRL is the one executing; its fields act on the next edge.
module microcode_sequencer #(
  parameter int OPCODE_W = 6,
  parameter int UOP_W    = 5,
  parameter int CTRL_W   = 32,
  parameter int CSEL_W   = 3
) (
  input  logic                    N_CLK,
  input  logic                    N_RST,
  input  logic                    STALL,
  input  logic [OPCODE_W-1:0]     OPCODE_IN,
  input  logic [2**CSEL_W-3:0]    COND,
  input  logic                    INT_REQ,
  output logic [OPCODE_W+UOP_W:0] UCODE_ADDR,
  input  logic [CTRL_W-1:0]       UCODE_DATA,
  output logic [CTRL_W-1:0]       CTRL,
  output logic [UOP_W-1:0]        UPC,
  output logic                    INT_ENABLED,
  output logic                    UOP_OVF
);

  localparam int NSRC    = 2**CSEL_W;
  localparam int END_B   = CTRL_W - 1;
  localparam int LOAD_B  = CTRL_W - 2;
  localparam int SET_B   = CTRL_W - 3;
  localparam int CLR_B   = CTRL_W - 4;
  localparam int CSEL_HI = CTRL_W - 5;
  localparam int CSEL_LO = CTRL_W - 4 - CSEL_W;
  localparam logic [UOP_W-1:0] UPC_ONE = {{(UOP_W-1){1'b0}}, 1'b1};

  // Architectural state and its next-state values
  logic [CTRL_W-1:0]   ctrl_q,   ctrl_d;
  logic [UOP_W-1:0]    upc_q,    upc_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                int_en_q, int_en_d;
  logic                ovf_q,    ovf_d;
  logic                pend_q,   pend_d;
  // Two-flop synchroniser for the asynchronous interrupt request
  logic [1:0]          sync_q;

  // Decoded fields of the executing word
  logic                end_f, load_f, set_f, clr_f;
  logic [CSEL_W-1:0]   csel;
  logic [NSRC-1:0]     cond_src;
  logic                has_interrupt;
  logic                cond_var;

  assign end_f  = ctrl_q[END_B];
  assign load_f = ctrl_q[LOAD_B];
  assign set_f  = ctrl_q[SET_B];
  assign clr_f  = ctrl_q[CLR_B];
  assign csel   = ctrl_q[CSEL_HI:CSEL_LO];

  // Source 0 is constant zero, source 1 the gated interrupt, the rest external flags
  assign has_interrupt = pend_q & int_en_q;
  assign cond_src      = {COND, has_interrupt, 1'b0};
  assign cond_var      = cond_src[csel];

  assign UCODE_ADDR  = {cond_var, opcode_q, upc_q};
  assign CTRL        = ctrl_q;
  assign UPC         = upc_q;
  assign INT_ENABLED = int_en_q;
  assign UOP_OVF     = ovf_q;

  // Next-state logic: everything holds while stalled
  always_comb begin
    ctrl_d   = ctrl_q;
    upc_d    = upc_q;
    opcode_d = opcode_q;
    int_en_d = int_en_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    if (!STALL) begin
      ctrl_d   = UCODE_DATA;
      upc_d    = end_f ? '0 : upc_q + UPC_ONE;
      opcode_d = load_f ? OPCODE_IN : opcode_q;
      // Clear has priority over set when both are coded in one word
      if (clr_f) begin
        int_en_d = 1'b0;
      end else if (set_f) begin
        int_en_d = 1'b1;
      end
      // Wrapping from all-ones without END is an error; END on all-ones is legal
      ovf_d    = ovf_q | ((&upc_q) & ~end_f);
      pend_d   = sync_q[1];
    end
  end

  // Interrupt synchroniser runs every edge, independent of STALL
  always_ff @(posedge N_CLK or negedge N_RST) begin
    if (!N_RST) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], INT_REQ};
    end
  end

  // Sequencer state register with asynchronous clear
  always_ff @(posedge N_CLK or negedge N_RST) begin
    if (!N_RST) begin
      ctrl_q   <= '0;
      upc_q    <= '0;
      opcode_q <= '0;
      int_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      upc_q    <= upc_d;
      opcode_q <= opcode_d;
      int_en_q <= int_en_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_microcode_sequencer;

  logic        N_CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        STALL = 1'b0;
  logic [5:0]  OPCODE_IN = '0;
  logic [5:0]  COND = '0;
  logic        INT_REQ = 1'b0;
  logic [11:0] UCODE_ADDR;
  logic [31:0] UCODE_DATA;
  logic [31:0] CTRL;
  logic [4:0]  UPC;
  logic        INT_ENABLED;
  logic        UOP_OVF;

  logic [31:0] rom [0:4095];
  assign UCODE_DATA = rom[UCODE_ADDR];

  microcode_sequencer dut (
    .N_CLK      (N_CLK),
    .N_RST      (N_RST),
    .STALL      (STALL),
    .OPCODE_IN  (OPCODE_IN),
    .COND       (COND),
    .INT_REQ    (INT_REQ),
    .UCODE_ADDR (UCODE_ADDR),
    .UCODE_DATA (UCODE_DATA),
    .CTRL       (CTRL),
    .UPC        (UPC),
    .INT_ENABLED(INT_ENABLED),
    .UOP_OVF    (UOP_OVF)
  );

  always #5 N_CLK = ~N_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge N_CLK);
    #1;
  endtask

  task automatic fill_rom(input logic [31:0] w);
    for (int a = 0; a < 4096; a++) rom[a] = w;
  endtask

  task automatic do_reset();
    N_RST = 1'b0;
    STALL = 1'b0;
    INT_REQ = 1'b0;
    COND = '0;
    repeat (2) @(negedge N_CLK);
    N_RST = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctrl;
  int          m_upc;
  int          m_op;
  bit          m_ie, m_ovf, m_pend;
  bit          m_hist[$];   // INT_REQ value seen at each past edge

  task automatic model_reset();
    m_ctrl = 0; m_upc = 0; m_op = 0; m_ie = 0; m_ovf = 0; m_pend = 0;
    m_hist = {1'b0, 1'b0};
  endtask

  function automatic logic [11:0] m_addr();
    int sel;
    bit cv;
    sel = int'(m_ctrl[27:25]);
    if (sel == 0) cv = 0;
    else if (sel == 1) cv = m_pend & m_ie;
    else cv = COND[sel-2];
    return {cv, 6'(m_op), 5'(m_upc)};
  endfunction

  task automatic model_step();
    logic [31:0] w;
    bit np;
    w  = rom[m_addr()];
    np = m_hist[m_hist.size()-2];   // request as it stood two edges ago
    m_hist.push_back(INT_REQ);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    if (!STALL) begin
      if (m_upc == 31 && !m_ctrl[31]) m_ovf = 1;
      m_upc = m_ctrl[31] ? 0 : (m_upc + 1) % 32;
      if (m_ctrl[30]) m_op = int'(OPCODE_IN);
      if (m_ctrl[28]) m_ie = 0;
      else if (m_ctrl[29]) m_ie = 1;
      m_pend = np;
      m_ctrl = w;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        stall;
    logic [5:0]  op_in;
    logic [31:0] exp_ctrl;
    logic [4:0]  exp_upc;
    logic [11:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 6'h15, 32'h4000_0000, 5'd1, 12'h001};
    vecs[1] = '{1'b0, 6'h15, 32'h0000_0000, 5'd2, 12'h2A2};
    vecs[2] = '{1'b0, 6'h00, 32'h0000_0000, 5'd3, 12'h2A3};
    vecs[3] = '{1'b1, 6'h00, 32'h0000_0000, 5'd3, 12'h2A3};
    vecs[4] = '{1'b0, 6'h00, 32'h0000_0000, 5'd4, 12'h2A4};
    vecs[5] = '{1'b0, 6'h00, 32'h0000_1234, 5'd5, 12'h2A5};

    // Reset state and fetch sequence
    fill_rom(32'h0);
    rom[0]     = 32'h4000_0000;
    rom[12'h2A4] = 32'h0000_1234;
    N_RST = 1'b0;
    #12;
    check("rst_ctrl", 64'(CTRL), 64'h0);
    check("rst_upc",  64'(UPC), 64'h0);
    check("rst_ie",   64'(INT_ENABLED), 64'h0);
    check("rst_ovf",  64'(UOP_OVF), 64'h0);
    check("rst_addr", 64'(UCODE_ADDR), 64'h0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      STALL = vecs[i].stall;
      OPCODE_IN = vecs[i].op_in;
      tick();
      check($sformatf("tbl%0d_ctrl", i), 64'(CTRL), 64'(vecs[i].exp_ctrl));
      check($sformatf("tbl%0d_upc", i),  64'(UPC), 64'(vecs[i].exp_upc));
      check($sformatf("tbl%0d_addr", i), 64'(UCODE_ADDR), 64'(vecs[i].exp_addr));
    end
    STALL = 1'b0;

    // Branch: COND_SEL=2 picks COND[0] combinationally
    fill_rom(32'h0);
    rom[0] = 32'h0400_0000;
    do_reset();
    tick();
    COND = 6'b000001; #1;
    check("branch_c1", 64'(UCODE_ADDR[11]), 64'h1);
    COND = 6'b000000; #1;
    check("branch_c0", 64'(UCODE_ADDR[11]), 64'h0);
    COND = 6'b111110; #1;
    check("branch_other", 64'(UCODE_ADDR[11]), 64'h0);
    COND = '0;

    // Interrupt latency: visible exactly 3 edges after request
    fill_rom(32'h0200_0000);
    rom[0] = 32'h2200_0000;
    do_reset();
    tick(); tick();
    check("int_enabled", 64'(INT_ENABLED), 64'h1);
    INT_REQ = 1'b1;
    tick(); check("int_e1", 64'(UCODE_ADDR[11]), 64'h0);
    tick(); check("int_e2", 64'(UCODE_ADDR[11]), 64'h0);
    tick(); check("int_e3", 64'(UCODE_ADDR[11]), 64'h1);
    INT_REQ = 1'b0;

    // Set and clear together: clear wins
    fill_rom(32'h0);
    rom[0] = 32'h2000_0000;
    rom[1] = 32'h3000_0000;
    do_reset();
    tick(); tick();
    check("setclr_pre", 64'(INT_ENABLED), 64'h1);
    tick();
    check("setclr_post", 64'(INT_ENABLED), 64'h0);

    // Overflow: wrap without END
    fill_rom(32'h0);
    do_reset();
    repeat (31) tick();
    check("ovf_upc31", 64'(UPC), 64'd31);
    check("ovf_pre", 64'(UOP_OVF), 64'h0);
    tick();
    check("ovf_upc0", 64'(UPC), 64'd0);
    check("ovf_set", 64'(UOP_OVF), 64'h1);
    repeat (3) tick();
    check("ovf_sticky", 64'(UOP_OVF), 64'h1);

    // END on count 31 is a legal return to zero
    fill_rom(32'h0);
    rom[30] = 32'h8000_0000;
    do_reset();
    repeat (31) tick();
    check("end31_ctrl", 64'(CTRL), 64'h8000_0000);
    tick();
    check("end31_upc", 64'(UPC), 64'd0);
    check("end31_ovf", 64'(UOP_OVF), 64'h0);

    // Stall mid-instruction with interrupt arriving during the stall
    fill_rom(32'h0200_0000);
    rom[0] = 32'h6000_0000;
    OPCODE_IN = 6'h2B;
    do_reset();
    repeat (3) tick();
    check("stall_pre_addr", 64'(UCODE_ADDR), 64'h563);
    STALL = 1'b1;
    INT_REQ = 1'b1;
    OPCODE_IN = 6'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_ctrl", i), 64'(CTRL), 64'h0200_0000);
      check($sformatf("stall%0d_addr", i), 64'(UCODE_ADDR), 64'h563);
    end
    STALL = 1'b0;
    tick();
    check("stall_release", 64'(UCODE_ADDR), 64'hD64);
    INT_REQ = 1'b0;

    // Asynchronous reset between edges
    fill_rom(32'h0);
    rom[0] = 32'h4000_0000;
    OPCODE_IN = 6'h3F;
    do_reset();
    repeat (7) tick();
    check("arst_pre_upc", 64'(UPC), 64'd7);
    check("arst_pre_addr", 64'(UCODE_ADDR), 64'h7E7);
    @(negedge N_CLK); #1;
    N_RST = 1'b0;
    #1;
    check("arst_outs", 64'({CTRL, UPC, INT_ENABLED, UOP_OVF}), 64'h0);
    check("arst_addr", 64'(UCODE_ADDR), 64'h0);
    @(negedge N_CLK);
    N_RST = 1'b1;

    // Randomized run against the model
    for (int a = 0; a < 4096; a++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[31] = 1'b0;
      rom[a] = w;
    end
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      STALL = ($urandom_range(0, 3) == 0);
      COND = 6'($urandom);
      OPCODE_IN = 6'($urandom);
      if ($urandom_range(0, 9) == 0) INT_REQ = ~INT_REQ;
      #1;
      check("rand_addr_pre", 64'(UCODE_ADDR), 64'(m_addr()));
      model_step();
      tick();
      check("rand_state", 64'({CTRL, UPC, INT_ENABLED, UOP_OVF}),
            64'({m_ctrl, 5'(m_upc), m_ie, m_ovf}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
